// File: rtl/ym6045c_z80_win_arb.sv
`timescale 1ns/1ps
// Z80 $8000-$FFFF window onto the 68k bus: serial bank register plus one 68k cycle per access.
// Optional DTACK timeout is compiled in with YM6045C_DTACK_TIMEOUT_EN.
module ym6045c_z80_win_arb #(
    parameter int DTACK_TO = 15,
    parameter int BR_HOLD  = 2
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        bank_wr,
    input  logic        bank_d0,
    input  logic        win_req,
    input  logic        win_rnw,
    input  logic [14:0] z80_a,
    input  logic        BG_n,
    input  logic        AS_in_n,
    input  logic        BGACK_in_n,
    input  logic        DTACK_n,
    output logic [8:0]  bank,
    output logic        BR_n,
    output logic        BGACK_n,
    output logic        AS_n,
    output logic        RW,
    output logic [22:0] ma,
    output logic        uds_n,
    output logic        lds_n,
    output logic        win_wait_n,
    output logic        to_flag
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_OWN, S_STRB, S_END} state_t;

    state_t      state, state_nxt;
    logic [8:0]  bank_lat;
    logic [14:0] a_lat;
    logic        rnw_lat;
    logic [2:0]  hold_cnt;
    logic        hold_ok;
    logic        grant_ok;
    logic        timeout;
    logic        strb_done;

    // Serial bank load: each write shifts D0 in at the top.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n)
            bank <= '0;
        else if (bank_wr)
            bank <= {bank_d0, bank[8:1]};
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n)
            hold_cnt <= '0;
        else if (state != S_REQ)
            hold_cnt <= '0;
        else if (hold_cnt != 3'd7)
            hold_cnt <= hold_cnt + 3'd1;
    end

    assign hold_ok  = (hold_cnt >= 3'(BR_HOLD - 1));
    assign grant_ok = hold_ok && !BG_n && AS_in_n && BGACK_in_n;

`ifdef YM6045C_DTACK_TIMEOUT_EN
    logic [7:0] to_cnt;

    // STRB is only ever entered from OWN, so clearing there is clearing on entry.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n)
            to_cnt <= '0;
        else if (state == S_OWN)
            to_cnt <= '0;
        else if (state == S_STRB)
            to_cnt <= to_cnt + 8'd1;
    end

    assign timeout = (state == S_STRB) && ((to_cnt + 8'd1) == 8'(DTACK_TO));

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n)
            to_flag <= 1'b0;
        else if (timeout && DTACK_n)
            to_flag <= 1'b1;
    end
`else
    assign timeout = 1'b0;
    assign to_flag = 1'b0;
`endif

    assign strb_done = !DTACK_n || timeout;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (win_req)   state_nxt = S_REQ;
            S_REQ:   if (grant_ok)  state_nxt = S_OWN;
            S_OWN:                  state_nxt = S_STRB;
            S_STRB:  if (strb_done) state_nxt = S_END;
            S_END:   if (!win_req)  state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    // Bus-side outputs are registered and change on the transition that enters each state.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            bank_lat   <= '0;
            a_lat      <= '0;
            rnw_lat    <= 1'b1;
            BR_n       <= 1'b1;
            BGACK_n    <= 1'b1;
            AS_n       <= 1'b1;
            uds_n      <= 1'b1;
            lds_n      <= 1'b1;
            RW         <= 1'b1;
            ma         <= '0;
            win_wait_n <= 1'b1;
        end else begin
            case (state)
                S_IDLE: if (win_req) begin
                    bank_lat   <= bank;
                    a_lat      <= z80_a;
                    rnw_lat    <= win_rnw;
                    win_wait_n <= 1'b0;
                    BR_n       <= 1'b0;
                end
                S_REQ: if (grant_ok) begin
                    BGACK_n <= 1'b0;
                    ma      <= {bank_lat, a_lat[14:1]};
                    RW      <= rnw_lat;
                end
                S_OWN: begin
                    BR_n  <= 1'b1;
                    AS_n  <= 1'b0;
                    uds_n <= a_lat[0];
                    lds_n <= !a_lat[0];
                end
                S_STRB: if (strb_done) begin
                    AS_n       <= 1'b1;
                    uds_n      <= 1'b1;
                    lds_n      <= 1'b1;
                    win_wait_n <= 1'b1;
                end
                S_END: if (!win_req) begin
                    BGACK_n <= 1'b1;
                    RW      <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
